// File: rtl/vga_pixel_queue_if.sv
// ============================================================================
// Module      : vga_pixel_queue_if
// Description : Pixel-stream input and framebuffer write port of vga_pixel_queue
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface vga_pixel_queue_if;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        fb_ready;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we;

  // master: drawing muxer plus framebuffer side; slave: the queue itself
  modport master (
    output vga_x, vga_y, vga_colour, vga_plot, fb_ready,
    input  fb_addr, fb_data, fb_we
  );

  modport slave (
    input  vga_x, vga_y, vga_colour, vga_plot, fb_ready,
    output fb_addr, fb_data, fb_we
  );
endinterface

`default_nettype wire

// File: rtl/vga_pixel_queue.sv
// ============================================================================
// Module      : vga_pixel_queue
// Description : Buffers the plot stream in a FIFO and drains it into the
//               160x120 framebuffer; optional clipping via VGA_PIXEL_QUEUE_CLIP_EN
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_pixel_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  wire logic       CLOCK_50,
  input  wire logic       Reset,
  vga_pixel_queue_if.slave bus,
  input  wire logic       clr_status,
  output logic            busy,
  output logic            overflow,
  output logic [7:0]      drop_count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t        state;
  logic [17:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic [14:0]   pix_addr;
  logic          in_range;
  logic          push_req;
  logic          pop;
  logic          push;
  logic          drop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [17:0]   head;

  // y*160 + x as two shifts and an add; the operands never exceed 15 bits
  assign pix_addr = {1'b0, bus.vga_y, 7'b0} + {3'b0, bus.vga_y, 5'b0} + {7'b0, bus.vga_x};

`ifdef VGA_PIXEL_QUEUE_CLIP_EN
  assign in_range = (bus.vga_x < 8'd160) && (bus.vga_y < 7'd120);
`else
  assign in_range = 1'b1;
`endif

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];

  // Pop uses the registered count, so a pixel pushed into an empty FIFO
  // waits one edge before it can be loaded.
  assign pop      = !fifo_empty && ((state == IDLE) || bus.fb_ready);
  assign push_req = bus.vga_plot && in_range;
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  assign busy = !fifo_empty || (state == WRITE);

  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem[wr_ptr] <= {pix_addr, bus.vga_colour};
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      bus.fb_we   <= 1'b0;
      bus.fb_addr <= '0;
      bus.fb_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            bus.fb_addr <= head[17:3];
            bus.fb_data <= head[2:0];
            bus.fb_we   <= 1'b1;
            state       <= WRITE;
          end
        end
        WRITE: begin
          if (bus.fb_ready) begin
            if (!fifo_empty) begin
              bus.fb_addr <= head[17:3];
              bus.fb_data <= head[2:0];
            end else begin
              bus.fb_we <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          bus.fb_we <= 1'b0;
        end
      endcase
    end
  end

  // A drop on the same edge as a clear wins and restarts the count at one
  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_status) begin
        drop_count <= 8'd1;
      end else if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end else if (clr_status) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_queue.sv
// ============================================================================
// Module      : tb_vga_pixel_queue
// Description : Scoreboard bench for vga_pixel_queue against a queue-level model
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_pixel_queue;
  localparam int DEPTH = 16;

  logic       CLOCK_50 = 1'b0;
  logic       Reset    = 1'b0;
  logic       clr_status;
  logic       busy;
  logic       overflow;
  logic [7:0] drop_count;

  vga_pixel_queue_if pif ();

  vga_pixel_queue #(.DEPTH(DEPTH), .AW(4)) dut (
    .CLOCK_50  (CLOCK_50),
    .Reset     (Reset),
    .bus       (pif),
    .clr_status(clr_status),
    .busy      (busy),
    .overflow  (overflow),
    .drop_count(drop_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: pixels the framebuffer is still owed, in order
  logic [17:0] exp_q[$];
  int          m_cnt;      // entries queued but not yet handed to the write port
  bit          m_loaded;   // a write is currently being presented
  bit          m_ovf;
  int          m_drops;

  function automatic bit model_in_range(input int x, input int y);
`ifdef VGA_PIXEL_QUEUE_CLIP_EN
    return (x < 160) && (y < 120);
`else
    return 1'b1;
`endif
  endfunction

  // Inputs are driven just after rising edges, so at the falling edge they
  // are the values the next rising edge will sample.
  always @(negedge CLOCK_50) begin
    bit pop, done, acc, want;
    logic [17:0] e;
    if (!Reset) begin
      exp_q.delete();
      m_cnt = 0; m_loaded = 0; m_ovf = 0; m_drops = 0;
    end
    chk("busy",       int'(busy),       int'(m_cnt != 0 || m_loaded));
    chk("fb_we",      int'(pif.fb_we),  int'(m_loaded));
    chk("overflow",   int'(overflow),   int'(m_ovf));
    chk("drop_count", int'(drop_count), m_drops);
    if (Reset) begin
      done = m_loaded && pif.fb_ready;
      pop  = (m_cnt > 0) && (!m_loaded || pif.fb_ready);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("stray_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", int'(pif.fb_addr), int'(e[17:3]));
          chk("wr_data", int'(pif.fb_data), int'(e[2:0]));
        end
      end
      want = pif.vga_plot && model_in_range(int'(pif.vga_x), int'(pif.vga_y));
      acc  = want && ((m_cnt < DEPTH) || pop);
      if (acc) begin
        e[17:3] = 15'((int'(pif.vga_y) * 160 + int'(pif.vga_x)) & 32'h7FFF);
        e[2:0]  = pif.vga_colour;
        exp_q.push_back(e);
      end
      m_cnt = m_cnt + int'(acc) - int'(pop);
      if (pop)       m_loaded = 1;
      else if (done) m_loaded = 0;
      if (want && !acc) begin
        m_ovf   = 1;
        m_drops = clr_status ? 1 : ((m_drops == 255) ? 255 : m_drops + 1);
      end else if (clr_status) begin
        m_ovf   = 0;
        m_drops = 0;
      end
    end
  end

  task automatic step(input bit p, input int x, input int y, input int c);
    pif.vga_plot   = p;
    pif.vga_x      = 8'(x);
    pif.vga_y      = 7'(y);
    pif.vga_colour = 3'(c);
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    pif.fb_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      step(0, 0, 0, 0);
      n++;
    end
    chk({name, "_drain_timeout"}, int'(n >= 400), 0);
  endtask

  initial begin
    pif.vga_plot = 0; pif.vga_x = 0; pif.vga_y = 0; pif.vga_colour = 0;
    pif.fb_ready = 1; clr_status = 0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_fb_we", int'(pif.fb_we), 0);
    chk("rst_fb_addr", int'(pif.fb_addr), 0);
    chk("rst_fb_data", int'(pif.fb_data), 0);
    chk("rst_busy", int'(busy), 0);
    Reset = 1;
    step(0, 0, 0, 0);

    // single pixel: load one edge after the plot edge, write completes on the next
    step(1, 79, 59, 5);
    pif.vga_plot = 0;
    @(negedge CLOCK_50);
    chk("single_we_early", int'(pif.fb_we), 0);
    @(posedge CLOCK_50); #1;
    chk("single_we", int'(pif.fb_we), 1);
    chk("single_addr", int'(pif.fb_addr), 9519);
    chk("single_data", int'(pif.fb_data), 5);
    @(posedge CLOCK_50); #1;
    chk("single_we_off", int'(pif.fb_we), 0);
    chk("single_busy", int'(busy), 0);

    // full-screen stream
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        step(1, x, y, (x + y) & 7);
    drain("screen");
    chk("screen_ovf", int'(overflow), 0);
    chk("screen_drops", int'(drop_count), 0);

    // stall: 20 plots into a stalled write port
    pif.fb_ready = 0;
    for (int i = 0; i < 20; i++) step(1, i, 3, i & 7);
    step(0, 0, 0, 0);
    chk("stall_ovf", int'(overflow), 1);
    chk("stall_drops", int'(drop_count), 3);
    drain("stall");

    clr_status = 1; step(0, 0, 0, 0); clr_status = 0;
    chk("clr_ovf", int'(overflow), 0);
    chk("clr_drops", int'(drop_count), 0);

    // full FIFO with a pop every cycle accepts every plot
    pif.fb_ready = 0;
    for (int i = 0; i < 17; i++) step(1, i, 7, 3);
    pif.fb_ready = 1;
    for (int i = 0; i < 30; i++) step(1, 100 + i, 8, i & 7);
    chk("fullpop_drops", int'(drop_count), 0);
    chk("fullpop_ovf", int'(overflow), 0);
    drain("fullpop");

    // clip corner cases
    step(1, 160, 10, 2);
    step(1, 5, 120, 6);
    drain("clip");
    chk("clip_drops", int'(drop_count), 0);

    // randomized traffic, with stall phases and occasional clears
    for (int blk = 0; blk < 40; blk++) begin
      int rdy_bias = $urandom_range(0, 3);
      for (int i = 0; i < 64; i++) begin
        pif.fb_ready = ($urandom_range(0, 3) < rdy_bias) ? 1'b1 : ($urandom_range(0, 7) == 0);
        clr_status   = ($urandom_range(0, 40) == 0);
        step($urandom_range(0, 3) != 0, $urandom_range(0, 175), $urandom_range(0, 127),
             $urandom_range(0, 7));
      end
    end
    clr_status = 0;
    drain("random");

    // reset in the middle of a stalled burst
    pif.fb_ready = 0;
    for (int i = 0; i < 10; i++) step(1, i, 50, 1);
    pif.vga_plot = 0;
    #3 Reset = 0;
    #1;
    chk("midrst_we", int'(pif.fb_we), 0);
    chk("midrst_busy", int'(busy), 0);
    @(posedge CLOCK_50); @(posedge CLOCK_50); #1;
    Reset = 1;
    pif.fb_ready = 1;
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
    chk("midrst_idle", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/vga_pixel_queue.md
# vga_pixel_queue

Downstream stage of the screen-clear / circle-draw datapath. It accepts the per-cycle pixel stream (x, y, colour, plot strobe) from the drawing muxer and buffers it in a small FIFO. It converts each pixel to a linear 160×120 framebuffer address and drains the FIFO into the framebuffer write port under a ready/write handshake. Plot bursts are therefore never lost to short memory stalls, and any loss that does occur is reported.

## Interface
Parameters:
- DEPTH, 16, FIFO entries (power of two, ≥2)
- AW, 4, log2(DEPTH)

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- Reset  in  1  asynchronous, active-low
- vga_x  in  8  pixel column
- vga_y  in  7  pixel row
- vga_colour  in  3  pixel colour
- vga_plot  in  1  pixel valid, sampled every rising edge
- fb_ready  in  1  framebuffer accepts a write this cycle
- clr_status  in  1  synchronous clear of overflow and drop_count
- fb_addr  out  15  linear address, y*160 + x
- fb_data  out  3  colour to write
- fb_we  out  1  write request
- busy  out  1  FIFO non-empty or write pending
- overflow  out  1  sticky: a valid pixel was dropped
- drop_count  out  8  dropped-pixel count, saturating

## Operation
- Push: on a rising edge with vga_plot=1 and the pixel accepted, store {addr, colour}.
  - addr = vga_y*160 + vga_x, computed as (y<<7)+(y<<5)+x.
  - Width is 15 bits and the result is truncated.
- Clipping (see Configuration): pixels with x>159 or y>119 are discarded silently. They are not counted as drops.
- Full handling:
  - If the FIFO is full and no pop occurs in the same cycle, the pixel is dropped.
  - On a drop, overflow is set to 1 and drop_count increments, saturating at 255.
  - If full with a simultaneous pop, the push is accepted and the count is unchanged.
- Drain FSM, two states:
  - IDLE: fb_we=0. If the FIFO is non-empty, load the head into fb_addr/fb_data, pop, and go to WRITE.
  - WRITE: fb_we=1, fb_addr/fb_data held stable.
    - On fb_ready=1 with the FIFO non-empty: load the next head, pop, stay in WRITE.
    - On fb_ready=1 with the FIFO empty: go to IDLE.
    - On fb_ready=0: hold everything.
- Push and pop in the same cycle are legal at any occupancy, including empty. A pixel pushed into an empty FIFO is popped no earlier than the following edge.
- clr_status=1: clears overflow and drop_count on that edge. A drop in the same cycle takes priority: overflow=1, drop_count=1.
- busy = (count≠0) | (state==WRITE).
- Pointer wrap: pointers are AW bits, wrap modulo DEPTH. Count is AW+1 bits, range 0..DEPTH.

## Timing
- Reset values:
  - state=IDLE, FIFO empty.
  - fb_we=0, fb_addr=0, fb_data=0.
  - overflow=0, drop_count=0, busy=0.
- Reset asserted mid-operation immediately empties the FIFO and deasserts fb_we. Buffered pixels are lost and are not counted.
- All outputs are registered except busy, which is a combinational function of registers.
- Latency:
  - Pixel sampled at edge N enters the FIFO at N.
  - It is loaded at N+1.
  - fb_we is high during cycle N+1→N+2.
  - With fb_ready=1 the write completes at edge N+2.
- Throughput: one write per cycle while fb_ready=1 and the FIFO is non-empty. There are no bubbles between back-to-back entries.
- fb_addr/fb_data change only at the edge where the IDLE load or the WRITE handshake completes.

## Configuration
- VGA_PIXEL_QUEUE_CLIP_EN defined: out-of-range pixels (x>159 or y>119) are discarded before push.
- VGA_PIXEL_QUEUE_CLIP_EN undefined:
  - Every plot is pushed.
  - The address is the truncated 15-bit y*160+x. Example: x=200, y=0 gives addr 200.
  - No range check logic is present.

## Test plan
- Single pixel: after reset, plot x=79, y=59, colour=5 with fb_ready=1.
  - Required: fb_we high exactly one cycle, fb_addr=9519, fb_data=5, starting 1 cycle after the plot edge.
  - Then busy=0.
- Full-screen stream: 19200 consecutive plots (x 0..159, y 0..119) with fb_ready=1.
  - Required: 19200 writes in order, addresses 0..19199, no overflow, drop_count=0.
- Stall/overflow (DEPTH=16): fb_ready=0, plot 20 pixels.
  - Required: 16 buffered (first one already loaded into fb_addr, so 17 accepted), overflow=1, drop_count=3.
  - Then raise fb_ready: exactly 17 writes in order.
- Full with simultaneous pop: FIFO full, fb_ready=1, plot each cycle.
  - Required: no drops, count stays at DEPTH.
- Clip (macro defined): plot x=160, y=10 and x=5, y=120.
  - Required: no writes, drop_count=0.
  - With macro undefined: writes to addr 1760 and 19205.
- Reset mid-burst: 10 pixels buffered with fb_ready=0, assert Reset.
  - Required: fb_we=0 and busy=0 immediately.
  - After release, no stale writes.
